// File: rtl/s64x7_pkg.sv
// Shared types and constants for the S64X7 64-bit to 16-bit SRAM bridge.
package s64x7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;

  // Expands byte selects into a 64-bit data mask.
  function automatic logic [63:0] byte_mask(input logic [7:0] sel);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/s64x7_bus_bridge16_if.sv
// 64-bit Wishbone-style slave bus plus the 16-bit asynchronous SRAM side.
// Handshake: a request is cyc_i&stb_i seen in IDLE; ack_o pulses exactly one
// cycle and dat_o is meaningful only while ack_o=1. Master holds no obligations
// after the accepting edge.
interface s64x7_bus_bridge16_if #(
  parameter int ADDR_W = 24
);
  logic [60:0]       adr_i;
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [7:0]        sel_i;
  logic [63:0]       dat_i;
  logic              ack_o;
  logic [63:0]       dat_o;
  logic [ADDR_W-2:0] mem_adr_o;
  logic [15:0]       mem_dat_o;
  logic [15:0]       mem_dat_i;
  logic              mem_cs_o;
  logic              mem_oe_o;
  logic              mem_we_o;
  logic [1:0]        mem_be_o;
  logic              mem_drive_o;

  modport slave (
    input  adr_i, cyc_i, stb_i, we_i, sel_i, dat_i, mem_dat_i,
    output ack_o, dat_o, mem_adr_o, mem_dat_o, mem_cs_o, mem_oe_o,
           mem_we_o, mem_be_o, mem_drive_o
  );

  modport master (
    output adr_i, cyc_i, stb_i, we_i, sel_i, dat_i, mem_dat_i,
    input  ack_o, dat_o, mem_adr_o, mem_dat_o, mem_cs_o, mem_oe_o,
           mem_we_o, mem_be_o, mem_drive_o
  );
endinterface

// File: rtl/s64x7_lane_picker.sv
// Finds the lowest selected halfword lane above (or at, when i_incl) i_lane.
module s64x7_lane_picker
  import s64x7_pkg::*;
(
  input  logic [7:0] i_sel,
  input  logic [1:0] i_lane,
  input  logic       i_incl,
  output logic [1:0] o_lane,
  output logic       o_none
);

  always_comb begin
    o_lane = 2'd0;
    o_none = 1'b1;
    // Descending scan so the last hit is the lowest qualifying lane.
    for (int k = LANES - 1; k >= 0; k--) begin
      if ((i_sel[2*k +: 2] != 2'b00) &&
          ((k > int'(i_lane)) || (i_incl && (k == int'(i_lane))))) begin
        o_lane = 2'(k);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/s64x7_bus_bridge16.sv
// Splits each 64-bit byte-selected bus access into sequential 16-bit SRAM
// accesses (SETUP + WAIT_STATES+1 ACCESS cycles per lane), then one ACK cycle.
module s64x7_bus_bridge16
  import s64x7_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  s64x7_bus_bridge16_if.slave     bus,
  output state_t                  dbg_state_o
);

  localparam int AW = ADDR_W - 3;

  state_t            r_state;
  logic [AW-1:0]     r_adr;
  logic              r_we;
  logic [7:0]        r_sel;
  logic [63:0]       r_dat;
  logic [1:0]        r_lane;
  logic [3:0]        r_wait;
  logic [63:0]       r_rbuf;
  logic              r_ack;
  logic [63:0]       r_dat_o;
  logic [ADDR_W-2:0] r_mem_adr;
  logic [15:0]       r_mem_dat;
  logic              r_cs;
  logic              r_oe;
  logic              r_mem_we;
  logic [1:0]        r_be;
  logic              r_drive;

  logic              w_req;
  logic [7:0]        w_src_sel;
  logic [63:0]       w_src_dat;
  logic [AW-1:0]     w_src_adr;
  logic              w_src_we;
  logic [1:0]        w_pick_lane;
  logic              w_pick_incl;
  logic [1:0]        w_next_lane;
  logic              w_none;
  logic [1:0]        w_lane_be;
  logic [15:0]       w_lane_dat;
  logic [63:0]       w_rbuf_next;
  logic              w_unused_adr;

  assign w_req        = bus.cyc_i & bus.stb_i;
  assign w_unused_adr = &{1'b0, bus.adr_i[60:AW]};

  // In IDLE the lane search runs on the live request so the first lane is
  // known at the accepting edge; afterwards it runs on the latched copy.
  always_comb begin
    w_src_sel   = bus.sel_i;
    w_src_dat   = bus.dat_i;
    w_src_adr   = bus.adr_i[AW-1:0];
    w_src_we    = bus.we_i;
    w_pick_lane = 2'd0;
    w_pick_incl = 1'b1;
    if (r_state != ST_IDLE) begin
      w_src_sel   = r_sel;
      w_src_dat   = r_dat;
      w_src_adr   = r_adr;
      w_src_we    = r_we;
      w_pick_lane = r_lane;
      w_pick_incl = 1'b0;
    end
    w_rbuf_next = r_rbuf;
    if (!r_we) w_rbuf_next[LANE_W*int'(r_lane) +: LANE_W] = bus.mem_dat_i;
  end

  s64x7_lane_picker u_picker (
    .i_sel  (w_src_sel),
    .i_lane (w_pick_lane),
    .i_incl (w_pick_incl),
    .o_lane (w_next_lane),
    .o_none (w_none)
  );

  assign w_lane_be  = w_src_sel[2*int'(w_next_lane) +: 2];
  assign w_lane_dat = w_src_dat[LANE_W*int'(w_next_lane) +: LANE_W];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
      r_lane    <= '0;
      r_wait    <= '0;
      r_rbuf    <= '0;
      r_ack     <= 1'b0;
      r_dat_o   <= '0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
      r_cs      <= 1'b0;
      r_oe      <= 1'b0;
      r_mem_we  <= 1'b0;
      r_be      <= '0;
      r_drive   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr <= bus.adr_i[AW-1:0];
            r_we  <= bus.we_i;
            r_sel <= bus.sel_i;
            r_dat <= bus.dat_i;
            if (w_none) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
              r_dat_o <= '0;
            end else begin
              r_state   <= ST_SETUP;
              r_lane    <= w_next_lane;
              r_mem_adr <= {w_src_adr, w_next_lane};
              r_be      <= w_lane_be;
              r_cs      <= 1'b1;
              r_drive   <= w_src_we;
              r_mem_dat <= w_src_we ? w_lane_dat : 16'h0;
            end
          end
        end
        ST_SETUP: begin
          r_state  <= ST_ACCESS;
          r_wait   <= 4'(WAIT_STATES);
          r_oe     <= ~r_we;
          r_mem_we <= r_we;
        end
        ST_ACCESS: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_rbuf   <= w_rbuf_next;
            r_oe     <= 1'b0;
            r_mem_we <= 1'b0;
            if (w_none) begin
              r_state   <= ST_ACK;
              r_ack     <= 1'b1;
              r_dat_o   <= r_we ? 64'h0 : (w_rbuf_next & byte_mask(r_sel));
              r_cs      <= 1'b0;
              r_drive   <= 1'b0;
              r_mem_adr <= '0;
              r_mem_dat <= '0;
              r_be      <= '0;
            end else begin
              r_state   <= ST_SETUP;
              r_lane    <= w_next_lane;
              r_mem_adr <= {w_src_adr, w_next_lane};
              r_be      <= w_lane_be;
              r_mem_dat <= r_we ? w_lane_dat : 16'h0;
            end
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_dat_o <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack_o       = r_ack;
  assign bus.dat_o       = r_dat_o;
  assign bus.mem_adr_o   = r_mem_adr;
  assign bus.mem_dat_o   = r_mem_dat;
  assign bus.mem_cs_o    = r_cs;
  assign bus.mem_oe_o    = r_oe;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_be_o    = r_be;
  assign bus.mem_drive_o = r_drive;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_s64x7_bus_bridge16.sv
// Directed bench for s64x7_bus_bridge16: vector table on a WAIT_STATES=1
// instance, back-to-back on a WAIT_STATES=0 instance, async reset mid-ACCESS.
module tb_s64x7_bus_bridge16;
  import s64x7_pkg::*;

  localparam int ADDR_W = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s64x7_bus_bridge16_if #(.ADDR_W(ADDR_W)) bus1 ();
  s64x7_bus_bridge16_if #(.ADDR_W(ADDR_W)) bus0 ();
  state_t st1, st0;

  s64x7_bus_bridge16 #(.ADDR_W(ADDR_W), .WAIT_STATES(1)) u_dut_w1 (
    .clk_i(clk), .reset_i(rst), .bus(bus1), .dbg_state_o(st1));
  s64x7_bus_bridge16 #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) u_dut_w0 (
    .clk_i(clk), .reset_i(rst), .bus(bus0), .dbg_state_o(st0));

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]  sel = '0;
  logic [60:0] adr = '0;
  logic [63:0] dat = '0;
  logic        use_w0 = 1'b0;

  assign bus1.cyc_i = cyc;  assign bus0.cyc_i = cyc;
  assign bus1.stb_i = stb;  assign bus0.stb_i = stb;
  assign bus1.we_i  = we;   assign bus0.we_i  = we;
  assign bus1.sel_i = sel;  assign bus0.sel_i = sel;
  assign bus1.adr_i = adr;  assign bus0.adr_i = adr;
  assign bus1.dat_i = dat;  assign bus0.dat_i = dat;

  // Observed outputs of whichever instance is under test.
  logic              m_ack, m_cs, m_oe, m_we, m_drive;
  logic [63:0]       m_dat_o;
  logic [ADDR_W-2:0] m_adr;
  logic [15:0]       m_wdat;
  logic [1:0]        m_be;
  state_t            m_st;
  assign m_ack   = use_w0 ? bus0.ack_o       : bus1.ack_o;
  assign m_cs    = use_w0 ? bus0.mem_cs_o    : bus1.mem_cs_o;
  assign m_oe    = use_w0 ? bus0.mem_oe_o    : bus1.mem_oe_o;
  assign m_we    = use_w0 ? bus0.mem_we_o    : bus1.mem_we_o;
  assign m_drive = use_w0 ? bus0.mem_drive_o : bus1.mem_drive_o;
  assign m_dat_o = use_w0 ? bus0.dat_o       : bus1.dat_o;
  assign m_adr   = use_w0 ? bus0.mem_adr_o   : bus1.mem_adr_o;
  assign m_wdat  = use_w0 ? bus0.mem_dat_o   : bus1.mem_dat_o;
  assign m_be    = use_w0 ? bus0.mem_be_o    : bus1.mem_be_o;
  assign m_st    = use_w0 ? st0              : st1;

  // ---------------- SRAM model ----------------
  logic [15:0] sram [0:255];
  assign bus1.mem_dat_i = sram[bus1.mem_adr_o[7:0]];
  assign bus0.mem_dat_i = sram[bus0.mem_adr_o[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      sram[8'h40] <= 16'h1111;
      sram[8'h41] <= 16'h2222;
      sram[8'h42] <= 16'h3333;
      sram[8'h43] <= 16'h4444;
    end else if (m_we) begin
      if (m_be[0]) sram[m_adr[7:0]][7:0]  <= m_wdat[7:0];
      if (m_be[1]) sram[m_adr[7:0]][15:8] <= m_wdat[15:8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge; returns just after the edge where ack_o rose.
  // lat counts edges from the first edge after the call up to that one.
  task automatic run_req(input logic w, input logic [7:0] s, input logic [60:0] a,
                         input logic [63:0] d, input bit keep,
                         output int lat, output logic [63:0] got, output logic [3:0] lanes,
                         output int we_cyc, output bit cs_seen, output bit conflict,
                         output logic [1:0] last_be, output logic [15:0] last_wdat,
                         output bit bad_adr);
    state_t pre;
    bit     dropped;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    lat = 0; got = 'x; lanes = '0; we_cyc = 0; cs_seen = 0; conflict = 0;
    last_be = '0; last_wdat = '0; bad_adr = 0; dropped = 0;
    forever begin
      pre = m_st;
      @(posedge clk);
      lat++;
      #1;
      if (!keep && !dropped && pre == ST_IDLE) begin
        stb = 1'b0; cyc = 1'b0; dropped = 1;
      end
      if (m_cs) begin
        cs_seen = 1;
        lanes[m_adr[1:0]] = 1'b1;
        last_be = m_be;
        if (m_adr[ADDR_W-2:2] != a[ADDR_W-4:0]) bad_adr = 1;
      end
      if (m_we) begin
        we_cyc++;
        last_wdat = m_wdat;
      end
      if (m_drive && m_oe) conflict = 1;
      if (m_ack) begin
        got = m_dat_o;
        break;
      end
      if (lat > 300) begin
        lat = -1; stb = 1'b0; cyc = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  sel;
    logic [60:0] adr;
    logic [63:0] dat;
    logic [63:0] exp_dat;
    int          exp_lat;
    logic [3:0]  exp_lanes;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat, we_cyc;
    logic [63:0] got;
    logic [3:0]  lanes;
    bit          cs_seen, conflict, bad_adr;
    logic [1:0]  lbe;
    logic [15:0] lwd;
    int          acks, cs_cnt;

    vecs[0] = '{1'b0, 8'hFF, 61'h10, 64'h0, 64'h4444_3333_2222_1111, 13, 4'hF, 2'b11, 16'h0};
    vecs[1] = '{1'b1, 8'h04, 61'h10, 64'hABAB_ABAB_ABAB_ABAB, 64'h0, 4, 4'h2, 2'b01, 16'hABAB};
    vecs[2] = '{1'b0, 8'hC3, 61'h10, 64'h0, 64'h4444_0000_0000_1111, 7, 4'h9, 2'b11, 16'h0};
    vecs[3] = '{1'b0, 8'h00, 61'h10, 64'h0, 64'h0, 1, 4'h0, 2'b00, 16'h0};
    vecs[4] = '{1'b0, 8'h04, 61'h10, 64'h0, 64'h0000_0000_00AB_0000, 4, 4'h2, 2'b01, 16'h0};
    vecs[5] = '{1'b1, 8'h30, 61'h11, 64'h1234_5A5A_9876_5432, 64'h0, 4, 4'h4, 2'b11, 16'h5A5A};
    vecs[6] = '{1'b0, 8'h30, 61'h11, 64'h0, 64'h0000_5A5A_0000_0000, 4, 4'h4, 2'b11, 16'h0};
    vecs[7] = '{1'b0, 8'h80, 61'h10, 64'h0, 64'h4400_0000_0000_0000, 4, 4'h8, 2'b10, 16'h0};
    vecs[8] = '{1'b1, 8'h00, 61'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 4'h0, 2'b00, 16'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {63'h0, m_ack},   64'h0);
    check("rst_cs",    {63'h0, m_cs},    64'h0);
    check("rst_dat_o", m_dat_o,          64'h0);
    check("rst_adr",   64'(m_adr),       64'h0);
    check("rst_state", 64'(m_st),        64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table on the WAIT_STATES=1 instance
    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, 1'b0,
              lat, got, lanes, we_cyc, cs_seen, conflict, lbe, lwd, bad_adr);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_dat_o", i), got, vecs[i].exp_dat);
      check($sformatf("v%0d_lanes", i), 64'(lanes), 64'(vecs[i].exp_lanes));
      check($sformatf("v%0d_we_cycles", i), 64'(we_cyc),
            vecs[i].we ? 64'($countones(vecs[i].exp_lanes) * 2) : 64'h0);
      check($sformatf("v%0d_be", i), 64'(lbe), 64'(vecs[i].exp_be));
      check($sformatf("v%0d_wdat", i), 64'(lwd), 64'(vecs[i].exp_wdat));
      check($sformatf("v%0d_cs_seen", i), 64'(cs_seen), 64'(vecs[i].exp_lanes != 4'h0));
      check($sformatf("v%0d_bad_adr", i), 64'(bad_adr), 64'h0);
      check($sformatf("v%0d_conflict", i), 64'(conflict), 64'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ack_pulse", i), {63'h0, m_ack}, 64'h0);
    end

    // Back-to-back write then read, WAIT_STATES=0, cyc held
    repeat (4) @(posedge clk);
    #1;
    use_w0 = 1'b1;
    run_req(1'b1, 8'h0F, 61'h20, 64'h7777_6666_BEEF_CAFE, 1'b1,
            lat, got, lanes, we_cyc, cs_seen, conflict, lbe, lwd, bad_adr);
    check("b2b_wr_latency", 64'(lat), 64'd5);
    check("b2b_wr_dat_o", got, 64'h0);
    check("b2b_wr_we_cycles", 64'(we_cyc), 64'd2);
    check("b2b_wr_conflict", 64'(conflict), 64'h0);
    run_req(1'b0, 8'h0F, 61'h20, 64'h0, 1'b0,
            lat, got, lanes, we_cyc, cs_seen, conflict, lbe, lwd, bad_adr);
    check("b2b_rd_latency_with_gap", 64'(lat), 64'd6);
    check("b2b_rd_dat_o", got, 64'h0000_0000_BEEF_CAFE);
    check("b2b_rd_lanes", 64'(lanes), 64'h3);
    check("b2b_rd_conflict", 64'(conflict), 64'h0);

    // Asynchronous reset in the middle of a write ACCESS
    repeat (30) @(posedge clk);
    #1;
    use_w0 = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 8'hFF; adr = 61'h30; dat = 64'h1;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    lat = 0;
    while (!m_we && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_mid_reached_access", 64'(m_we), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ack",   {63'h0, m_ack},   64'h0);
    check("rst_mid_cs",    {63'h0, m_cs},    64'h0);
    check("rst_mid_we",    {63'h0, m_we},    64'h0);
    check("rst_mid_drive", {63'h0, m_drive}, 64'h0);
    check("rst_mid_state", 64'(m_st),        64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    acks = 0; cs_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (m_ack) acks++;
      if (m_cs) cs_cnt++;
    end
    check("rst_mid_no_ack", 64'(acks), 64'h0);
    check("rst_mid_no_cs", 64'(cs_cnt), 64'h0);
    check("rst_mid_idle", 64'(m_st), 64'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
